// File: rtl/passthrough_lane_arbiter.sv
// Round-robin arbiter sharing one passthrough lane between N_REQ requesters.
// Optional lane self-check is built when LANE_ARB_CHECK_EN is defined.
module passthrough_lane_arbiter #(
  parameter int N_REQ    = 12,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int LANE_LAT = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]       lane_in,
  input  logic [DATA_W-1:0]       lane_out,
  output logic                    lane_busy,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             xfer_count,
  output logic                    check_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   lane_in_q, lane_in_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [15:0]         xfer_count_q, xfer_count_d;

  logic [2*N_REQ-1:0]  dbl_s;
  logic [N_REQ-1:0]    rot_s;
  logic                grant_found_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic [DATA_W-1:0]   grant_data_s;
  int                  first_j_s;
  int                  sum_s;

  // Rotate the valid vector so bit 0 is the requester just after last_q, then pick the lowest set bit.
  always_comb begin
    dbl_s         = {req_valid, req_valid} >> ({1'b0, last_q} + {{ID_W{1'b0}}, 1'b1});
    rot_s         = dbl_s[N_REQ-1:0];
    grant_found_s = |rot_s;
    first_j_s     = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        first_j_s = j;
      end else begin
        first_j_s = first_j_s;
      end
    end
    sum_s = int'(last_q) + 1 + first_j_s;
    if (sum_s >= N_REQ) begin
      sum_s = sum_s - N_REQ;
    end else begin
      sum_s = sum_s;
    end
    grant_idx_s  = ID_W'(sum_s);
    grant_data_s = DATA_W'(req_data >> (int'(grant_idx_s) * DATA_W));
  end

  // Accept strobe is combinational and only offered while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found_s) begin
      req_ready = N_REQ'(1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

`ifdef LANE_ARB_CHECK_EN
  logic check_err_q, check_err_d;
`endif

  // Next-state and datapath updates for the IDLE/WAIT/RESP transaction sequence.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    lane_in_d    = lane_in_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    xfer_count_d = xfer_count_q;
`ifdef LANE_ARB_CHECK_EN
    check_err_d  = check_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          lane_in_d = grant_data_s;
          id_d      = grant_idx_s;
          last_d    = grant_idx_s;
          cnt_d     = 4'(LANE_LAT);
          state_d   = ST_WAIT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end else begin
          resp_data_d = lane_out;
          resp_id_d   = id_q;
          state_d     = ST_RESP;
`ifdef LANE_ARB_CHECK_EN
          // A mismatch is only flagged; the response still carries what the lane returned.
          if (lane_out != lane_in_q) begin
            check_err_d = 1'b1;
          end else begin
            check_err_d = check_err_q;
          end
`endif
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          xfer_count_d = xfer_count_q + 16'd1;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_q       <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      cnt_q        <= 4'd0;
      lane_in_q    <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      xfer_count_q <= 16'd0;
`ifdef LANE_ARB_CHECK_EN
      check_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      lane_in_q    <= lane_in_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      xfer_count_q <= xfer_count_d;
`ifdef LANE_ARB_CHECK_EN
      check_err_q  <= check_err_d;
`endif
    end
  end

  assign lane_in    = lane_in_q;
  assign lane_busy  = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign xfer_count = xfer_count_q;
`ifdef LANE_ARB_CHECK_EN
  assign check_err  = check_err_q;
`else
  assign check_err  = 1'b0;
`endif

endmodule

// File: tb/tb_passthrough_lane_arbiter.sv
// Directed self-checking bench for passthrough_lane_arbiter (zero-latency and 3-cycle lane instances).
module tb_passthrough_lane_arbiter;
  localparam int N = 12;
  localparam int W = 32;
`ifdef LANE_ARB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]  lane_in, lane_out;
  logic          lane_busy, resp_valid, resp_ready;
  logic [W-1:0]  resp_data;
  logic [3:0]    resp_id;
  logic [15:0]   xfer_count;
  logic          check_err;
  logic          corrupt;

  logic [N-1:0]  l3_req_valid, l3_req_ready;
  logic [N*W-1:0] l3_req_data;
  logic [W-1:0]  l3_lane_in, l3_lane_out, l3_d1, l3_d2, l3_d3;
  logic          l3_lane_busy, l3_resp_valid, l3_resp_ready;
  logic [W-1:0]  l3_resp_data;
  logic [3:0]    l3_resp_id;
  logic [15:0]   l3_xfer_count;
  logic          l3_check_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc, prev_acc;

  passthrough_lane_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(4), .LANE_LAT(0)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .lane_in(lane_in), .lane_out(lane_out), .lane_busy(lane_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .xfer_count(xfer_count), .check_err(check_err));

  passthrough_lane_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(4), .LANE_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_data(l3_req_data), .lane_in(l3_lane_in), .lane_out(l3_lane_out), .lane_busy(l3_lane_busy),
    .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_data(l3_resp_data),
    .resp_id(l3_resp_id), .xfer_count(l3_xfer_count), .check_err(l3_check_err));

  // Zero-latency lane, optionally corrupting input 0x4 into 0xDEAD.
  assign lane_out = (corrupt && lane_in == 32'h4) ? 32'hDEAD : lane_in;

  // Three-cycle lane delay line.
  always_ff @(posedge clock) begin
    l3_d1 <= l3_lane_in;
    l3_d2 <= l3_d1;
    l3_d3 <= l3_d2;
  end
  assign l3_lane_out = l3_d3;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_ready(input int bound);
    #1;
    for (int k = 0; k < bound && req_ready == '0; k++) step();
    check_eq("ready_timeout", 32'(req_ready != '0), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; corrupt = 1'b0; resp_ready = 1'b1; req_valid = '0;
    l3_req_valid = '0; l3_resp_ready = 1'b1; l3_req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'(i + 1);
    l3_req_data[5*W +: W] = 32'h6;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_lane_in", lane_in, 32'h0);
    check_eq("rst_busy", 32'(lane_busy), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_data", resp_data, 32'h0);
    check_eq("rst_resp_id", 32'(resp_id), 32'h0);
    check_eq("rst_xfer", 32'(xfer_count), 32'h0);
    check_eq("rst_check_err", 32'(check_err), 32'h0);
    do_reset();

    // Single request from requester 0.
    req_valid = 12'h001;
    wait_ready(8);
    check_eq("t1_ready", 32'(req_ready), 32'h001);
    step();
    req_valid = '0;
    check_eq("t1_ready_drop", 32'(req_ready), 32'h0);
    check_eq("t1_busy", 32'(lane_busy), 32'h1);
    check_eq("t1_lane_in", lane_in, 32'h1);
    check_eq("t1_no_resp_yet", 32'(resp_valid), 32'h0);
    step();
    check_eq("t1_resp_valid", 32'(resp_valid), 32'h1);
    check_eq("t1_resp_data", resp_data, 32'h1);
    check_eq("t1_resp_id", 32'(resp_id), 32'h0);
    step();
    check_eq("t1_resp_drop", 32'(resp_valid), 32'h0);
    check_eq("t1_xfer", 32'(xfer_count), 32'h1);
    check_eq("t1_idle", 32'(lane_busy), 32'h0);

    // All requesters valid: round-robin 0..11,0 with 3-cycle spacing.
    do_reset();
    req_valid = '1;
    prev_acc = 0;
    for (int n = 0; n < 13; n++) begin
      wait_ready(8);
      acc_cyc = cyc;
      check_eq("rr_grant", 32'(req_ready), 32'(12'h001 << (n % N)));
      if (n > 0) check_eq("rr_spacing", 32'(acc_cyc - prev_acc), 32'd3);
      prev_acc = acc_cyc;
      step();
      step();
      check_eq("rr_resp_id", 32'(resp_id), 32'(n % N));
      check_eq("rr_resp_data", resp_data, 32'((n % N) + 1));
      step();
      if (n == 11) check_eq("rr_xfer12", 32'(xfer_count), 32'd12);
    end
    req_valid = '0;

    // Backpressure with requester 2 in flight; next grant skips to 5 from {1,2,5}.
    resp_ready = 1'b0;
    req_valid = 12'h004;
    wait_ready(8);
    check_eq("bp_grant2", 32'(req_ready), 32'h004);
    step();
    req_valid = 12'h026;
    step();
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid", 32'(resp_valid), 32'h1);
      check_eq("bp_id", 32'(resp_id), 32'h2);
      check_eq("bp_data", resp_data, 32'h3);
      check_eq("bp_no_ready", 32'(req_ready), 32'h0);
      step();
    end
    resp_ready = 1'b1;
    step();
    #1;
    check_eq("bp_next_grant", 32'(req_ready), 32'h020);
    check_eq("bp_xfer", 32'(xfer_count), 32'd14);
    req_valid = '0;
    step();

    // Reset during WAIT drops the in-flight transaction.
    req_valid = 12'h080;
    wait_ready(8);
    check_eq("rw_grant7", 32'(req_ready), 32'h080);
    step();
    req_valid = '0;
    check_eq("rw_in_wait", 32'(lane_busy), 32'h1);
    reset = 1'b0;
    #1;
    check_eq("rw_busy", 32'(lane_busy), 32'h0);
    check_eq("rw_lane_in", lane_in, 32'h0);
    check_eq("rw_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rw_xfer", 32'(xfer_count), 32'h0);
    step();
    reset = 1'b1;
    step();
    step();
    check_eq("rw_no_resp", 32'(resp_valid), 32'h0);
    req_valid = 12'h081;
    wait_ready(8);
    check_eq("rw_grant0", 32'(req_ready), 32'h001);
    req_valid = '0;
    step();

    // Corrupted lane: 0x4 comes back as 0xDEAD; error flag sticky when the check is built.
    corrupt = 1'b1;
    req_valid = 12'h008;
    wait_ready(8);
    check_eq("ce_grant3", 32'(req_ready), 32'h008);
    step();
    req_valid = '0;
    step();
    check_eq("ce_resp_valid", 32'(resp_valid), 32'h1);
    check_eq("ce_resp_data", resp_data, 32'hDEAD);
    check_eq("ce_resp_id", 32'(resp_id), 32'h3);
    check_eq("ce_err", 32'(check_err), 32'(EXP_ERR));
    step();
    req_valid = 12'h010;
    wait_ready(8);
    step();
    req_valid = '0;
    step();
    check_eq("ce_good_data", resp_data, 32'h5);
    check_eq("ce_err_sticky", 32'(check_err), 32'(EXP_ERR));
    step();
    corrupt = 1'b0;

    // Three-cycle lane: requester 5 with 0x6, response at accept+4.
    l3_req_valid = 12'h020;
    #1;
    check_eq("l3_grant5", 32'(l3_req_ready), 32'h020);
    step();
    l3_req_valid = '0;
    check_eq("l3_lane_in", l3_lane_in, 32'h6);
    step();
    check_eq("l3_busy", 32'(l3_lane_busy), 32'h1);
    check_eq("l3_early1", 32'(l3_resp_valid), 32'h0);
    step();
    step();
    check_eq("l3_early3", 32'(l3_resp_valid), 32'h0);
    step();
    check_eq("l3_resp_valid", 32'(l3_resp_valid), 32'h1);
    check_eq("l3_resp_data", l3_resp_data, 32'h6);
    check_eq("l3_resp_id", 32'(l3_resp_id), 32'h5);
    check_eq("l3_err", 32'(l3_check_err), 32'h0);
    step();
    check_eq("l3_resp_drop", 32'(l3_resp_valid), 32'h0);
    check_eq("l3_xfer", 32'(l3_xfer_count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
